// File: rtl/ide_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ide_cycle_ctrl
// Description : 68000-bus to IDE drive cycle sequencer. Turns a decoded IDE
//               bus cycle into a timed IOR_n/IOW_n strobe with a
//               mode-dependent active length and recovery time. Also hosts
//               a 2-bit timing mode register reachable through reg_sel.
// Ports       : CLK7M       - 7.09 MHz clock, rising edge
//               RESET       - synchronous active-low reset
//               AS_n, UDS_n, LDS_n, RW - 68000 bus controls
//               ide_access  - IDE window address decode hit
//               ide_enable  - gates new cycles
//               reg_sel     - 1: timing register, 0: drive access
//               DIN[3:0]    - data bits 15:12 (mode write data in 13:12)
//               IOR_n/IOW_n - registered drive strobes
//               DTACK       - registered cycle acknowledge
//               DOUT[3:0]   - mode readback {2'b00, mode}
//               dout_oe     - DOUT bus drive enable
//               busy        - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module ide_cycle_ctrl (
  input  logic       CLK7M,
  input  logic       RESET,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       ide_access,
  input  logic       ide_enable,
  input  logic       reg_sel,
  input  logic [3:0] DIN,
  output logic       IOR_n,
  output logic       IOW_n,
  output logic       DTACK,
  output logic [3:0] DOUT,
  output logic       dout_oe,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_ACK     = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic [1:0] r_mode;
  logic [1:0] r_act_cnt;   // remaining strobe cycles minus one
  logic       r_rec_cnt;   // remaining recovery cycles minus one
  logic       r_reg_cyc;   // current cycle targets the timing register
  logic       r_ior_n;
  logic       r_iow_n;
  logic       r_dtack;
  logic       w_ior_n_nx;
  logic       w_iow_n_nx;
  logic       w_dtack_nx;
  logic       w_start;
  logic       w_unused_din;

  assign w_start = ide_access && !AS_n && (!UDS_n || !LDS_n) && ide_enable;

  // Only DIN[1:0] (bus bits 13:12) carry mode data.
  assign w_unused_din = ^DIN[3:2];

  // Next-state and next-output decode. The strobe outputs are registered from
  // the state that is current at the edge, so the strobe trails STROBE entry
  // by one edge (giving the SETUP cycle), while AS_n going high releases
  // IOR_n/DTACK on the very edge it is sampled.
  always_comb begin
    w_state_nx = r_state;
    w_ior_n_nx = 1'b1;
    w_iow_n_nx = 1'b1;
    w_dtack_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nx = reg_sel ? S_ACK : S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_nx = AS_n ? S_RECOVER : S_STROBE;
      end
      S_STROBE: begin
        if (AS_n) begin
          w_state_nx = S_RECOVER;
        end else begin
          if (RW) begin
            w_ior_n_nx = 1'b0;
          end else begin
            w_iow_n_nx = 1'b0;
          end
          if (r_act_cnt == 2'd0) begin
            w_state_nx = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (AS_n) begin
          w_state_nx = S_RECOVER;
        end else begin
          w_dtack_nx = 1'b1;
          // Reads keep IOR_n low so drive data stays valid until the CPU latches it.
          if (!r_reg_cyc && RW) begin
            w_ior_n_nx = 1'b0;
          end
        end
      end
      S_RECOVER: begin
        if (!r_rec_cnt) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK7M) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_mode    <= 2'd0;
      r_act_cnt <= 2'd0;
      r_rec_cnt <= 1'b0;
      r_reg_cyc <= 1'b0;
      r_ior_n   <= 1'b1;
      r_iow_n   <= 1'b1;
      r_dtack   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ior_n <= w_ior_n_nx;
      r_iow_n <= w_iow_n_nx;
      r_dtack <= w_dtack_nx;
      case (r_state)
        S_IDLE: begin
          // Timing is frozen from the mode in force at the start edge, so a
          // register write never reshapes the cycle it belongs to.
          if (w_start) begin
            r_act_cnt <= 2'd3 - r_mode;
            r_rec_cnt <= (r_mode == 2'd0);
            r_reg_cyc <= reg_sel;
            if (reg_sel && !RW) begin
              r_mode <= DIN[1:0];
            end
          end
        end
        S_STROBE: begin
          if (!AS_n && (r_act_cnt != 2'd0)) begin
            r_act_cnt <= r_act_cnt - 2'd1;
          end
        end
        S_RECOVER: begin
          if (r_rec_cnt) begin
            r_rec_cnt <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign IOR_n   = r_ior_n;
  assign IOW_n   = r_iow_n;
  assign DTACK   = r_dtack;
  assign DOUT    = {2'b00, r_mode};
  assign dout_oe = (r_state == S_ACK) && r_reg_cyc && RW;
  assign busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ide_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ide_cycle_ctrl
// Description : Self-checking bench for ide_cycle_ctrl. Directed vector table,
//               hand-built corner sequences and a randomized run compared
//               against a timestamp-based transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ide_cycle_ctrl;

  logic       CLK7M;
  logic       RESET;
  logic       AS_n;
  logic       UDS_n;
  logic       LDS_n;
  logic       RW;
  logic       ide_access;
  logic       ide_enable;
  logic       reg_sel;
  logic [3:0] DIN;
  logic       IOR_n;
  logic       IOW_n;
  logic       DTACK;
  logic [3:0] DOUT;
  logic       dout_oe;
  logic       busy;

  ide_cycle_ctrl dut (
    .CLK7M      (CLK7M),
    .RESET      (RESET),
    .AS_n       (AS_n),
    .UDS_n      (UDS_n),
    .LDS_n      (LDS_n),
    .RW         (RW),
    .ide_access (ide_access),
    .ide_enable (ide_enable),
    .reg_sel    (reg_sel),
    .DIN        (DIN),
    .IOR_n      (IOR_n),
    .IOW_n      (IOW_n),
    .DTACK      (DTACK),
    .DOUT       (DOUT),
    .dout_oe    (dout_oe),
    .busy       (busy)
  );

  initial CLK7M = 1'b0;
  always #5 CLK7M = ~CLK7M;

  // ctl = {RESET, AS_n, data strobes, RW, ide_access, ide_enable, reg_sel}
  // e   = {IOR_n, IOW_n, DTACK, dout_oe, busy, DOUT[3:0]}
  typedef struct {
    logic [6:0] ctl;
    logic [3:0] din;
    logic [8:0] e;
  } vec_t;

  vec_t tbl [15];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Transaction model state: a cycle is described by its start edge, its
  // frozen timing, and the edge at which AS_n ended it.
  bit         m_act;
  bit         m_reg;
  int         m_s;
  int         m_A;
  int         m_R;
  int         m_ack;
  int         m_end;
  logic [1:0] m_mode;

  function automatic logic [8:0] exp9(input logic ior, input logic iow, input logic dtk,
                                      input logic oe, input logic bsy, input logic [3:0] d);
    return {ior, iow, dtk, oe, bsy, d};
  endfunction

  task automatic drive(input logic [6:0] ctl, input logic [3:0] din);
    @(negedge CLK7M);
    RESET      = ctl[6];
    AS_n       = ctl[5];
    UDS_n      = ctl[4];
    LDS_n      = ctl[4];
    RW         = ctl[3];
    ide_access = ctl[2];
    ide_enable = ctl[1];
    reg_sel    = ctl[0];
    DIN        = din;
    @(posedge CLK7M);
    #1;
  endtask

  task automatic check(input string nm, input logic [8:0] e);
    logic [8:0] got;
    got = {IOR_n, IOW_n, DTACK, dout_oe, busy, DOUT};
    n_chk++;
    if (got === e) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got {ior,iow,dtack,oe,busy,dout}=%b required %b", nm, got, e);
    end
  endtask

  task automatic model_step(input int k, input logic [6:0] ctl, input logic [3:0] din,
                            output logic [8:0] e);
    bit live;
    if (!ctl[6]) begin
      m_act  = 0;
      m_mode = 2'd0;
      m_end  = -1;
    end else if (!m_act) begin
      if (ctl[2] && !ctl[5] && !ctl[4] && ctl[1]) begin
        m_act = 1;
        m_s   = k;
        m_reg = ctl[0];
        m_A   = 4 - int'(m_mode);
        m_R   = (m_mode == 2'd0) ? 2 : 1;
        m_ack = ctl[0] ? k + 1 : k + 2 + m_A;
        m_end = -1;
        if (ctl[0] && !ctl[3]) m_mode = din[1:0];
      end
    end else if (m_end < 0) begin
      if (ctl[5]) m_end = k;
    end else if (k == m_end + m_R) begin
      m_act = 0;
    end
    live = m_act && (m_end < 0);
    e = exp9(!(live && !m_reg && ctl[3] && k >= m_s + 2),
             !(live && !m_reg && !ctl[3] && k >= m_s + 2 && k <= m_s + 1 + m_A),
             live && k >= m_ack,
             live && m_reg && ctl[3],
             m_act,
             {2'b00, m_mode});
  endtask

  initial begin
    logic [8:0] e;
    logic [6:0] ctl;
    logic       as_v;

    RESET = 1'b0; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
    ide_access = 1'b0; ide_enable = 1'b1; reg_sel = 1'b0; DIN = 4'h0;

    // Register write of mode 3, then a mode-3 drive write, then readback.
    tbl[0]  = '{7'b1000111, 4'h3, 9'b11001_0011};
    tbl[1]  = '{7'b1000111, 4'h3, 9'b11101_0011};
    tbl[2]  = '{7'b1110010, 4'h0, 9'b11001_0011};
    tbl[3]  = '{7'b1110010, 4'h0, 9'b11001_0011};
    tbl[4]  = '{7'b1110010, 4'h0, 9'b11000_0011};
    tbl[5]  = '{7'b1000110, 4'h0, 9'b11001_0011};
    tbl[6]  = '{7'b1000110, 4'h0, 9'b11001_0011};
    tbl[7]  = '{7'b1000110, 4'h0, 9'b10001_0011};
    tbl[8]  = '{7'b1000110, 4'h0, 9'b11101_0011};
    tbl[9]  = '{7'b1110010, 4'h0, 9'b11001_0011};
    tbl[10] = '{7'b1110010, 4'h0, 9'b11000_0011};
    tbl[11] = '{7'b1001111, 4'h0, 9'b11011_0011};
    tbl[12] = '{7'b1001111, 4'h0, 9'b11111_0011};
    tbl[13] = '{7'b1111010, 4'h0, 9'b11001_0011};
    tbl[14] = '{7'b1111010, 4'h0, 9'b11000_0011};

    // Reset values, including a register write attempted under reset.
    drive(7'b0111010, 4'h0);  check("reset_idle",  9'b11000_0000);
    drive(7'b0000111, 4'h3);  check("reset_block", 9'b11000_0000);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].ctl, tbl[i].din);
      check($sformatf("vec%0d", i), tbl[i].e);
    end

    // Reset mid-STROBE (mode 3), immediate restart, mode readback, enable off.
    drive(7'b1001110, 4'h0);  check("rst_mid_start", 9'b11001_0011);
    drive(7'b1001110, 4'h0);  check("rst_mid_setup", 9'b11001_0011);
    drive(7'b0001110, 4'h0);  check("rst_mid_edge",  9'b11000_0000);
    drive(7'b1001111, 4'h0);  check("rst_rd_ack",    9'b11011_0000);
    drive(7'b1001111, 4'h0);  check("rst_rd_dtack",  9'b11111_0000);
    drive(7'b1111010, 4'h0);  check("rst_rd_end",    9'b11001_0000);
    drive(7'b1111010, 4'h0);  check("rst_rd_rec",    9'b11001_0000);
    drive(7'b1111010, 4'h0);  check("rst_rd_idle",   9'b11000_0000);
    for (int i = 0; i < 3; i++) begin
      drive(7'b1001100, 4'h0);  check("enable_off", 9'b11000_0000);
    end

    // Mode 0 drive read, AS_n released 10 edges after the start.
    for (int off = 0; off < 14; off++) begin
      drive((off < 10) ? 7'b1001110 : 7'b1111010, 4'h0);
      check($sformatf("m0_read_%0d", off),
            exp9(!(off >= 2 && off <= 9), 1'b1, (off >= 6 && off <= 9), 1'b0,
                 (off <= 11), 4'h0));
    end

    // Mode 0 write aborted in STROBE; register write while busy is ignored.
    drive(7'b1000110, 4'h0);  check("abort_start",  9'b11001_0000);
    drive(7'b1000110, 4'h0);  check("abort_setup",  9'b11001_0000);
    drive(7'b1000110, 4'h0);  check("abort_strobe", 9'b10001_0000);
    drive(7'b1110010, 4'h0);  check("abort_edge",   9'b11001_0000);
    drive(7'b1000111, 4'h2);  check("busy_wr_ign",  9'b11001_0000);
    drive(7'b1110010, 4'h0);  check("abort_idle",   9'b11000_0000);
    drive(7'b1110010, 4'h0);  check("abort_idle2",  9'b11000_0000);
    drive(7'b1001111, 4'h0);  check("rdback_ack",   9'b11011_0000);
    drive(7'b1001111, 4'h0);  check("rdback_dtack", 9'b11111_0000);
    drive(7'b1111010, 4'h0);  check("rdback_end",   9'b11001_0000);
    drive(7'b1111010, 4'h0);  check("rdback_rec",   9'b11001_0000);
    drive(7'b1111010, 4'h0);  check("rdback_idle",  9'b11000_0000);

    // Randomized run against the transaction model.
    m_act = 0; m_reg = 0; m_s = 0; m_A = 4; m_R = 2; m_ack = 0; m_end = -1; m_mode = 2'd0;
    as_v = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 6) == 0) as_v = ~as_v;
      ctl[6] = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      ctl[5] = as_v;
      ctl[4] = ($urandom_range(0, 5) == 0);
      ctl[3] = $urandom_range(0, 1) != 0;
      ctl[2] = ($urandom_range(0, 3) != 0);
      ctl[1] = ($urandom_range(0, 9) != 0);
      ctl[0] = ($urandom_range(0, 3) == 0);
      drive(ctl, 4'($urandom_range(0, 15)));
      model_step(i, ctl, DIN, e);
      check("random", e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
